lsfr: RTL and testbench
=======================

LSFR -- requirements
Module: lsfr

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning register/output width; legal range 3..16.
REQ-002 SHALL have parameter RESET_VALUE, default all-zeros (WIDTH bits), meaning state loaded on reset.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port comp_rand  output  WIDTH  current pseudo-random state, driven directly from the state register.

Function
REQ-006 SHALL implement a Fibonacci shift-right LFSR with XNOR feedback, advancing once per rising clk edge when reset is low.
REQ-007 SHALL compute next state as {fb, comp_rand[WIDTH-1:1]}; fb is the XNOR of all tap bits.
REQ-008 SHALL take taps from exponent set E(WIDTH); exponent e maps to bit comp_rand[WIDTH-e].
REQ-009 SHALL use these E tables: 3:{3,2}; 4:{4,3}; 5:{5,3}; 6:{6,5}; 7:{7,6}; 8:{8,6,5,4}; 9:{9,5}; 10:{10,7}; 11:{11,9}; 12:{12,6,4,1}; 13:{13,4,3,1}; 14:{14,5,3,1}; 15:{15,14}; 16:{16,15,13,4}.
REQ-010 SHALL, for WIDTH=10, compute fb = comp_rand[0] XNOR comp_rand[3].
REQ-011 SHALL produce a maximal-length sequence: period 2^WIDTH-1 from any state except all-ones.
REQ-012 SHALL treat all-ones as the XNOR lock-up state: without the recovery feature, all-ones maps to itself.
REQ-013 SHALL have zero latency: comp_rand reflects the new state in the same cycle as the clock edge; there is no handshake and no enable.
REQ-014 SHALL produce a WIDTH=10 sequence from reset of 0x000 -> 0x200 -> 0x300 -> 0x380 -> 0x3C0 -> 0x3E0 -> 0x3F0 -> 0x3F8 -> 0x1FC.

Reset
REQ-015 SHALL load comp_rand = RESET_VALUE on any rising edge where reset = 1, including mid-sequence; reset has priority over the shift.
REQ-016 SHALL make the first shift occur on the first rising edge where reset = 0.
REQ-017 SHALL leave comp_rand undefined before the first reset; no initial value is required.

Configuration
REQ-018 SHALL, with macro LSFR_LOCKUP_RECOVER_EN defined, force the next state to all-zeros when the state is all-ones and reset = 0.
REQ-019 SHALL, with LSFR_LOCKUP_RECOVER_EN undefined, leave the all-ones state stuck (REQ-012) and add no recovery logic.
REQ-020 SHALL leave behaviour in all other states identical with or without the macro.

Structure
REQ-021 SHALL place the tap table (REQ-009), the WIDTH_MIN=3 / WIDTH_MAX=16 constants and a function returning the tap mask for a given WIDTH in package lsfr_pkg.
REQ-022 SHALL isolate the feedback XNOR reduction in one sub-module, lsfr_feedback: state in, tap mask parameter, fb out.
REQ-023 SHALL reject a WIDTH outside 3..16 at elaboration with a fatal error.

Verification
REQ-024 SHALL verify: WIDTH=10, reset high for 2 cycles, then low for 8 cycles -> comp_rand = 0x000 during reset, then 0x200, 0x300, 0x380, 0x3C0, 0x3E0, 0x3F0, 0x3F8, 0x1FC.
REQ-025 SHALL verify: WIDTH=10, run 1023 cycles after reset -> all 1023 non-all-ones values appear exactly once and state returns to 0x000 at cycle 1023.
REQ-026 SHALL verify: reset asserted at cycle 5 of the run -> comp_rand = 0x000 on the next edge, and the sequence restarts at 0x200.
REQ-027 SHALL verify: RESET_VALUE = 0x3FF, macro undefined -> comp_rand stays 0x3FF for 20 cycles; macro defined -> 0x3FF, then 0x000, then 0x200.
REQ-028 SHALL verify: WIDTH in {3, 4, 8, 16} from reset 0 -> period exactly 2^WIDTH-1 with no all-ones state visited.

Source files
------------

// File: rtl/lsfr_pkg.sv
// -----------------------------------------------------------------------------
// lsfr_pkg
//   Shared constants and tap tables for the XNOR Fibonacci LFSR.
//
//   WIDTH_MIN / WIDTH_MAX : legal range of the LFSR width.
//   tap_exponents(width)  : bit e of the result is set when exponent e is a
//                           tap of the maximal-length polynomial for 'width'.
//   tap_mask(width)       : the same taps translated to state bit positions.
//                           Exponent e lands on state bit (width - e), so the
//                           highest exponent is always bit 0 (the bit about
//                           to be shifted out).
//
//   Every table entry has an even number of taps, which is what makes the
//   all-ones word the single lock-up state of the XNOR form.
// -----------------------------------------------------------------------------
package lsfr_pkg;

  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 16;

  function automatic logic [WIDTH_MAX:0] tap_exponents(input int width);
    logic [WIDTH_MAX:0] e;
    e = '0;
    case (width)
      3:  begin e[3]  = 1'b1; e[2]  = 1'b1; end
      4:  begin e[4]  = 1'b1; e[3]  = 1'b1; end
      5:  begin e[5]  = 1'b1; e[3]  = 1'b1; end
      6:  begin e[6]  = 1'b1; e[5]  = 1'b1; end
      7:  begin e[7]  = 1'b1; e[6]  = 1'b1; end
      8:  begin e[8]  = 1'b1; e[6]  = 1'b1; e[5]  = 1'b1; e[4] = 1'b1; end
      9:  begin e[9]  = 1'b1; e[5]  = 1'b1; end
      10: begin e[10] = 1'b1; e[7]  = 1'b1; end
      11: begin e[11] = 1'b1; e[9]  = 1'b1; end
      12: begin e[12] = 1'b1; e[6]  = 1'b1; e[4]  = 1'b1; e[1] = 1'b1; end
      13: begin e[13] = 1'b1; e[4]  = 1'b1; e[3]  = 1'b1; e[1] = 1'b1; end
      14: begin e[14] = 1'b1; e[5]  = 1'b1; e[3]  = 1'b1; e[1] = 1'b1; end
      15: begin e[15] = 1'b1; e[14] = 1'b1; end
      16: begin e[16] = 1'b1; e[15] = 1'b1; e[13] = 1'b1; e[4] = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [WIDTH_MAX-1:0] tap_mask(input int width);
    logic [WIDTH_MAX:0]   e;
    logic [WIDTH_MAX-1:0] m;
    e = tap_exponents(width);
    m = '0;
    for (int k = 1; k <= WIDTH_MAX; k++) begin
      if (k <= width && e[k]) begin
        m[width-k] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/lsfr_feedback.sv
// -----------------------------------------------------------------------------
// lsfr_feedback
//   Feedback bit of the XNOR Fibonacci LFSR: the XNOR of every tapped state
//   bit. Pure combinational; the tap set is fixed at elaboration.
//
//   Parameters:
//     WIDTH    : state width
//     TAP_MASK : one bit per state bit, set where the bit is a tap
//   Ports:
//     i_state  in   WIDTH  current LFSR state
//     o_fb     out  1      feedback bit shifted into the MSB
// -----------------------------------------------------------------------------
module lsfr_feedback #(
  parameter int               WIDTH    = 10,
  parameter logic [WIDTH-1:0] TAP_MASK = '0
) (
  input  logic [WIDTH-1:0] i_state,
  output logic             o_fb
);

  // Untapped bits are masked to zero, so they do not change the parity.
  // With an even tap count, reduction XNOR equals a chained XNOR gate tree.
  assign o_fb = ~^(i_state & TAP_MASK);

endmodule

// File: rtl/lsfr.sv
// -----------------------------------------------------------------------------
// lsfr
//   Fibonacci shift-right LFSR with XNOR feedback. It advances once on every
//   rising clk edge where reset is low. The next state is {fb, state[W-1:1]}.
//   The output is the state register itself, so a new value shows up on the
//   same edge that produces it. There is no enable and no handshake.
//
//   Parameters:
//     WIDTH       : state/output width, 3..16 (anything else stops elaboration)
//     RESET_VALUE : state loaded on every edge where reset is high
//   Ports:
//     clk         in   1      rising-edge clock
//     reset       in   1      synchronous, active-high; has priority over shift
//     comp_rand   out  WIDTH  current pseudo-random state
//
//   Optional build macro:
//     LSFR_LOCKUP_RECOVER_EN : when defined, the all-ones lock-up state is
//                              followed by all-zeros. When undefined, all-ones
//                              repeats forever and no recovery logic is built.
// -----------------------------------------------------------------------------
module lsfr
  import lsfr_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] comp_rand
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $fatal(1, "lsfr: WIDTH %0d outside legal range %0d..%0d",
           WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  localparam logic [WIDTH_MAX-1:0] TAP_MASK_FULL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0]     TAP_MASK      = TAP_MASK_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] r_state;
  logic             w_fb;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_next;

  lsfr_feedback #(
    .WIDTH    (WIDTH),
    .TAP_MASK (TAP_MASK)
  ) u_feedback (
    .i_state (r_state),
    .o_fb    (w_fb)
  );

  assign w_shift = {w_fb, r_state[WIDTH-1:1]};

`ifdef LSFR_LOCKUP_RECOVER_EN
  // All-ones is the only state outside the maximal cycle. Sending it to
  // all-zeros puts the register back on the normal sequence.
  assign w_next = (r_state == '1) ? '0 : w_shift;
`else
  assign w_next = w_shift;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RESET_VALUE;
    end else begin
      r_state <= w_next;
    end
  end

  assign comp_rand = r_state;

endmodule

// File: tb/tb_lsfr.sv
module tb_lsfr;

  localparam int NL = 6;
  localparam int W  = 16 * NL;

  // Lane map: 0 w10 rv0, 1 w10 rv3FF, 2 w3, 3 w4, 4 w8, 5 w16
  localparam int LW [NL] = '{10, 10, 3, 4, 8, 16};

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  q10;
  logic [9:0]  q10s;
  logic [2:0]  q3;
  logic [3:0]  q4;
  logic [7:0]  q8;
  logic [15:0] q16;

  lsfr #(.WIDTH(10), .RESET_VALUE(10'h000)) u10  (.clk(clk), .reset(reset), .comp_rand(q10));
  lsfr #(.WIDTH(10), .RESET_VALUE(10'h3FF)) u10s (.clk(clk), .reset(reset), .comp_rand(q10s));
  lsfr #(.WIDTH(3),  .RESET_VALUE(3'h0))    u3   (.clk(clk), .reset(reset), .comp_rand(q3));
  lsfr #(.WIDTH(4),  .RESET_VALUE(4'h0))    u4   (.clk(clk), .reset(reset), .comp_rand(q4));
  lsfr #(.WIDTH(8),  .RESET_VALUE(8'h00))   u8   (.clk(clk), .reset(reset), .comp_rand(q8));
  lsfr #(.WIDTH(16), .RESET_VALUE(16'h0000)) u16 (.clk(clk), .reset(reset), .comp_rand(q16));

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [15:0] ms  [NL];
  logic [15:0] rvs [NL] = '{16'h0, 16'h3FF, 16'h0, 16'h0, 16'h0, 16'h0};
  string       lane_name [NL] = '{"w10", "w10_rv3ff", "w3", "w4", "w8", "w16"};
  logic [15:0] trace [8] = '{16'h200, 16'h300, 16'h380, 16'h3C0,
                             16'h3E0, 16'h3F0, 16'h3F8, 16'h1FC};
  int          seen10 [1024];
  int          per    [NL];
  bit          ones_hit [NL];

  // Reference model: a polynomial-level view. Taps are listed as exponents,
  // the feedback is 1 when an even number of tapped bits are 1, and the
  // word shifts right with the feedback entering at the top.
  function automatic logic [15:0] model_next(input int w, input logic [15:0] s);
    int          e [4];
    int          n;
    int          ones;
    logic [15:0] all_ones;
    logic        fb;
    case (w)
      3:  begin e = '{3, 2, 0, 0};     n = 2; end
      4:  begin e = '{4, 3, 0, 0};     n = 2; end
      8:  begin e = '{8, 6, 5, 4};     n = 4; end
      10: begin e = '{10, 7, 0, 0};    n = 2; end
      16: begin e = '{16, 15, 13, 4};  n = 4; end
      default: begin e = '{0, 0, 0, 0}; n = 0; end
    endcase
    all_ones = 16'((32'd1 << w) - 1);
`ifdef LSFR_LOCKUP_RECOVER_EN
    if (s == all_ones) return 16'h0;
`else
    if (all_ones == 16'h0) return 16'h0;
`endif
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(s[w - e[i]]);
    fb = ((ones % 2) == 0);
    return (s >> 1) | (16'(fb) << (w - 1));
  endfunction

  function automatic logic [W-1:0] pack_actual();
    logic [W-1:0] v;
    v = '0;
    v[0*16 +: 16] = 16'(q10);
    v[1*16 +: 16] = 16'(q10s);
    v[2*16 +: 16] = 16'(q3);
    v[3*16 +: 16] = 16'(q4);
    v[4*16 +: 16] = 16'(q8);
    v[5*16 +: 16] = 16'(q16);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // One clock of stimulus: drive reset, let the edge happen, advance the
  // model and queue what every lane must show after that edge.
  task automatic step(input logic r);
    logic [W-1:0] e;
    reset = r;
    @(posedge clk);
    e = '0;
    for (int i = 0; i < NL; i++) begin
      ms[i] = r ? rvs[i] : model_next(LW[i], ms[i]);
      e[16*i +: 16] = ms[i];
    end
    exp_q.push_back(e);
    #1;
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = pack_actual();
        for (int i = 0; i < NL; i++) begin
          check({"seq_", lane_name[i]}, 32'(a[16*i +: 16]), 32'(e[16*i +: 16]));
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [W-1:0] a;
    logic [15:0]  v;
    int           ok;

    for (int i = 0; i < 1024; i++) seen10[i] = 0;
    for (int i = 0; i < NL; i++) begin per[i] = 0; ones_hit[i] = 1'b0; end

    // Two reset cycles
    step(1'b1);
    check("reset_w10_c0", 32'(q10), 32'h000);
    step(1'b1);
    check("reset_w10_c1", 32'(q10), 32'h000);
    check("reset_w10_rv3ff", 32'(q10s), 32'h3FF);
    seen10[q10]++;

    // Long free run: covers the full period of every lane, up to 16 bits
    for (int cyc = 1; cyc <= 65540; cyc++) begin
      step(1'b0);
      if (cyc <= 8) check("trace_w10", 32'(q10), 32'(trace[cyc-1]));
      if (cyc <= 1022) seen10[q10]++;
      if (cyc == 1023) check("return_w10_c1023", 32'(q10), 32'h000);
`ifdef LSFR_LOCKUP_RECOVER_EN
      if (cyc == 1) check("recover_w10_c1", 32'(q10s), 32'h000);
      if (cyc == 2) check("recover_w10_c2", 32'(q10s), 32'h200);
`else
      if (cyc <= 20) check("lockup_w10", 32'(q10s), 32'h3FF);
`endif
      a = pack_actual();
      for (int i = 0; i < NL; i++) begin
        if (i != 1 && per[i] == 0) begin
          v = a[16*i +: 16];
          if (v == 16'h0) per[i] = cyc;
          if (v == 16'((32'd1 << LW[i]) - 1)) ones_hit[i] = 1'b1;
        end
      end
    end

    ok = 0;
    for (int i = 0; i < 1023; i++) if (seen10[i] == 1) ok++;
    check("coverage_w10_once", 32'(ok), 32'd1023);
    check("coverage_w10_allones", 32'(seen10[1023]), 32'd0);
    for (int i = 0; i < NL; i++) begin
      if (i != 1) begin
        check({"period_", lane_name[i]}, 32'(per[i]), (32'd1 << LW[i]) - 1);
        check({"no_allones_", lane_name[i]}, 32'(ones_hit[i]), 32'd0);
      end
    end

    // Mid-sequence reset
    step(1'b1);
    for (int k = 0; k < 5; k++) step(1'b0);
    step(1'b1);
    check("midrun_reset_w10", 32'(q10), 32'h000);
    step(1'b0);
    check("restart_w10_1", 32'(q10), 32'h200);
    step(1'b0);
    check("restart_w10_2", 32'(q10), 32'h300);

    // Random resets sprinkled into the run
    for (int k = 0; k < 400; k++) step($urandom_range(0, 7) == 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending expected=0 pending", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
